// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: state codes, ALU op codes,
// digit normalisation and the default WAIT timeout.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_A = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SHOW   = 3'd4,
    ST_ERR    = 3'd5
  } calc_state_e;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  localparam int DEFAULT_TIMEOUT = 15;

  // Keys above 9 are not BCD digits and are treated as 0.
  function automatic logic [3:0] norm_digit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd0 : d;
  endfunction

endpackage

// File: rtl/calc_timeout.sv
// 8-bit WAIT-cycle counter with clear, enable and a terminal-count flag that
// fires during the TIMEOUT-th enabled cycle.
module calc_timeout
  import calc_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 8'd0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed WAIT cycles, so TIMEOUT-1 marks the TIMEOUT-th one.
  assign expired = en && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/calc_seq.sv
// Calculator ALU sequencer: collects operands/op from the keypad, pulses the
// ALU, waits with timeout and holds the result. Optional CALC_CHAIN_EN chains results.
module calc_seq
  import calc_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [3:0]       Digit,
  input  logic             Enter,
  input  logic             Clear,
  input  logic [1:0]       Op,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [1:0]       AluOp,
  output logic             AluStart,
  input  logic             AluDone,
  input  logic [WIDTH-1:0] AluResult,
  output logic [WIDTH-1:0] Result,
  output logic             Error,
  output logic [2:0]       State
);

  calc_state_e      state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]       op_q, op_d;
  logic             err_q, err_d, start_q, start_d;
  logic             to_clr, to_en, to_expired;

  assign to_clr = Clear || (state_q == ST_EXEC);
  assign to_en  = !Clear && (state_q == ST_WAIT);

  calc_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  // AluStart is a one-cycle request; AluDone is only accepted while in WAIT.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    start_d = 1'b0;
    if (Clear) begin
      state_d = ST_LOAD_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = 2'd0;
      res_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD_A: if (Enter) begin
          a_d     = WIDTH'(norm_digit(Digit));
          state_d = ST_LOAD_B;
        end
        ST_LOAD_B: if (Enter) begin
          b_d     = WIDTH'(norm_digit(Digit));
          op_d    = Op;
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          start_d = 1'b1;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (AluDone) begin
            res_d   = AluResult;
            state_d = ST_SHOW;
          end else if (to_expired) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
        ST_SHOW: if (Enter) begin
`ifdef CALC_CHAIN_EN
          a_d     = res_q;
          state_d = ST_LOAD_B;
`else
          state_d = ST_LOAD_A;
`endif
        end
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_LOAD_A;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'd0;
      res_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  assign AluA     = a_q;
  assign AluB     = b_q;
  assign AluOp    = op_q;
  assign AluStart = start_q;
  assign Result   = res_q;
  assign Error    = err_q;
  assign State    = state_q;

endmodule

// File: tb/tb_calc_seq.sv
// Randomised bench for calc_seq with an operation-level reference model and a
// behavioural ALU responder driven from tasks.
module tb_calc_seq;
  import calc_pkg::*;

  localparam int W  = 4;
  localparam int TO = 5;

  logic         Clk, Rst_n, Enter, Clear, AluStart, AluDone, Error;
  logic [3:0]   Digit;
  logic [1:0]   Op, AluOp;
  logic [W-1:0] AluA, AluB, AluResult, Result;
  logic [2:0]   State;

  calc_seq #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Digit(Digit), .Enter(Enter), .Clear(Clear),
    .Op(Op), .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluStart(AluStart),
    .AluDone(AluDone), .AluResult(AluResult), .Result(Result), .Error(Error),
    .State(State)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  always @(negedge Clk) if (AluStart === 1'b1) start_cnt++;

  // reference model of the visible registers
  logic [W-1:0] m_a, m_b, m_res;
  logic [1:0]   m_op;
  logic         m_err;
  int           m_state;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] norm_ref(input logic [3:0] d);
    return (d <= 4'd9) ? W'(d) : '0;
  endfunction

  function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
    case (op)
      2'd0:    return W'(a + b);
      2'd1:    return W'(a - b);
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  task automatic model_zero();
    m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_err = 1'b0; m_state = 0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_a"},     AluA,   m_a);
    check_eq({tag, "_b"},     AluB,   m_b);
    check_eq({tag, "_op"},    AluOp,  m_op);
    check_eq({tag, "_res"},   Result, m_res);
    check_eq({tag, "_err"},   Error,  m_err);
    check_eq({tag, "_state"}, State,  m_state);
  endtask

  // driver tasks
  task automatic do_clear();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    model_zero();
    check_outputs("clear");
    check_eq("clear_start", AluStart, 1'b0);
  endtask

  task automatic enter_a(input logic [3:0] d);
    Digit = d; Enter = 1'b1;
    tick();
    Enter = 1'b0;
    m_a = norm_ref(d); m_state = 1;
    check_outputs("enter_a");
  endtask

  task automatic enter_b(input logic [3:0] d, input logic [1:0] op);
    Digit = d; Op = op; Enter = 1'b1;
    tick();
    Enter = 1'b0;
    m_b = norm_ref(d); m_op = op; m_state = 2;
    check_outputs("enter_b");
    check_eq("exec_start", AluStart, 1'b0);
  endtask

  // dly = WAIT cycle in which the ALU answers; beyond TO means no answer in time
  task automatic exec_wait(input int dly);
    int  s0;
    bit  fin;
    s0  = start_cnt;
    fin = 1'b0;
    tick();
    m_state = 3;
    check_eq("start_pulse", AluStart, 1'b1);
    check_eq("wait_state", State, 3);
    for (int k = 1; k <= TO; k++) begin
      if (!fin) begin
        if (k == dly) begin
          AluDone = 1'b1;
          AluResult = alu_ref(m_a, m_b, m_op);
          exp_q.push_back(AluResult);
        end else begin
          AluDone = 1'b0;
          AluResult = W'($urandom_range(0, 15));
          Enter = 1'($urandom_range(0, 1));
        end
        tick();
        AluDone = 1'b0;
        Enter = 1'b0;
        if (k == dly) begin
          m_res = exp_q.pop_front();
          m_state = 4;
          check_outputs("done");
          fin = 1'b1;
        end else if (k == TO) begin
          m_err = 1'b1;
          m_state = 5;
          check_outputs("timeout");
        end else begin
          check_outputs("wait");
          check_eq("wait_no_start", AluStart, 1'b0);
        end
      end
    end
    if (!fin) begin
      AluDone = 1'b1;
      AluResult = W'($urandom_range(0, 15));
      tick();
      AluDone = 1'b0;
      check_outputs("err_late_done");
      Enter = 1'b1;
      tick();
      Enter = 1'b0;
      check_outputs("err_enter");
    end
    check_eq("one_start", start_cnt - s0, 1);
  endtask

  task automatic leave_show();
    Digit = 4'($urandom_range(0, 15));
    Enter = 1'b1;
    tick();
    Enter = 1'b0;
`ifdef CALC_CHAIN_EN
    m_a = m_res;
    m_state = 1;
`else
    m_state = 0;
`endif
    check_outputs("leave_show");
  endtask

  initial begin
    int s0;
    Rst_n = 1'b0; Enter = 1'b0; Clear = 1'b0; Digit = '0; Op = '0;
    AluDone = 1'b0; AluResult = '0;
    model_zero();
    repeat (2) @(posedge Clk);
    #1;
    check_outputs("reset");
    check_eq("reset_start", AluStart, 1'b0);
    Rst_n = 1'b1;
    tick();

    // 3 + 4 with the ALU answering in the second WAIT cycle
    enter_a(4'd3);
    enter_b(4'd4, OP_ADD);
    exec_wait(2);
    check_eq("tp_sum", Result, 7);
    check_eq("tp_show", State, 4);
    leave_show();

`ifdef CALC_CHAIN_EN
    enter_b(4'd2, OP_SUB);
    check_eq("chain_a", AluA, 7);
    check_eq("chain_op", AluOp, 1);
    exec_wait(1);
    check_eq("chain_res", Result, 5);
`else
    enter_a(4'd12);
    enter_b(4'd9, OP_OR);
    check_eq("norm_a", AluA, 0);
    check_eq("norm_b", AluB, 9);
    check_eq("norm_op", AluOp, 3);
    exec_wait(3);
`endif
    do_clear();

    // no answer at all: timeout, error holds, only Clear exits
    enter_a(4'd5);
    enter_b(4'd6, OP_SUB);
    exec_wait(TO + 2);
    check_eq("to_error", Error, 1);
    do_clear();

    // answer on the very cycle the timeout would fire
    enter_a(4'd1);
    enter_b(4'd1, OP_ADD);
    exec_wait(TO);
    check_eq("edge_done_res", Result, 2);
    check_eq("edge_done_err", Error, 0);
    leave_show();
    do_clear();

    // Clear beats Enter in LOAD_B
    enter_a(4'd8);
    Digit = 4'd9; Enter = 1'b1; Clear = 1'b1;
    tick();
    Enter = 1'b0; Clear = 1'b0;
    model_zero();
    check_outputs("clr_enter");

    // Clear during WAIT, then a late AluDone is ignored
    enter_a(4'd2);
    enter_b(4'd3, OP_ADD);
    tick();
    check_eq("cw_start", AluStart, 1'b1);
    tick();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    model_zero();
    check_outputs("clr_wait");
    AluDone = 1'b1; AluResult = 4'd5;
    tick();
    AluDone = 1'b0;
    check_outputs("clr_late_done");

    // asynchronous reset while the start pulse is out
    enter_a(4'd4);
    enter_b(4'd5, OP_AND);
    tick();
    s0 = start_cnt;
    Rst_n = 1'b0;
    #2;
    model_zero();
    check_outputs("rst_mid");
    check_eq("rst_mid_start", AluStart, 1'b0);
    #1;
    Rst_n = 1'b1;
    AluDone = 1'b1; AluResult = 4'd9;
    tick();
    AluDone = 1'b0;
    repeat (3) tick();
    check_outputs("rst_after");
    check_eq("rst_no_restart", start_cnt - s0, 0);

    // random operations
    for (int i = 0; i < 25; i++) begin
      enter_a(4'($urandom_range(0, 15)));
      enter_b(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      exec_wait(int'($urandom_range(1, TO + 1)));
      if (m_err) begin
        do_clear();
      end else begin
        leave_show();
`ifdef CALC_CHAIN_EN
        do_clear();
`endif
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
